falling_piece_ctrl: RTL and testbench



---
 rtl/falling_piece_pkg.sv | 66 ++++++
 rtl/falling_piece_if.sv | 22 ++
 rtl/piece_pixel_hit.sv | 34 +++
 rtl/falling_piece_ctrl.sv | 140 ++++++++++++++
 tb/tb_falling_piece_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/falling_piece_pkg.sv
// Shared types, key codes, shape table and mask helpers for the falling-piece engine.
package falling_piece_pkg;

  typedef enum logic [1:0] {
    StFall,
    StSpawn,
    StPause
  } state_e;

  localparam logic [7:0] KeyLeft  = 8'h6B;
  localparam logic [7:0] KeyRight = 8'h74;
  localparam logic [7:0] KeyDrop  = 8'h72;
  localparam logic [7:0] KeyRot   = 8'h75;
  localparam logic [7:0] KeyPause = 8'h29;

  // Entry [0] is the rightmost element; bit r*4+c is cell (row r, col c).
  localparam logic [7:0][15:0] SHAPE_MASK = {
    16'h0000, 16'h0000, 16'h0000, 16'h0072,
    16'h0071, 16'h000F, 16'h00FF, 16'h0033
  };

  // Shift the mask up and left until row 0 and col 0 are both occupied.
  function automatic logic [15:0] normalise(logic [15:0] m);
    logic [15:0] n;
    n = m;
    for (int i = 0; i < 3; i++) begin
      if (n[3:0] == 4'h0 && n != 16'h0) n = n >> 4;
      if ((n & 16'h1111) == 16'h0 && n != 16'h0) n = (n >> 1) & 16'h7777;
    end
    return n;
  endfunction

  function automatic logic [15:0] rot_cw(logic [15:0] m);
    logic [15:0] t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[r*4+c] = m[(3-c)*4+r];
      end
    end
    return normalise(t);
  endfunction

  function automatic logic [5:0] mask_w(logic [15:0] m);
    logic [5:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[r*4+c] && w < 6'(c + 1)) w = 6'(c + 1);
      end
    end
    return w;
  endfunction

  function automatic logic [5:0] mask_h(logic [15:0] m);
    logic [5:0] h;
    h = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[r*4+c] && h < 6'(r + 1)) h = 6'(r + 1);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/falling_piece_if.sv
// Key input, pixel query and piece status bundle between the game logic and the piece engine.
interface falling_piece_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_hit;
  logic [2:0] piece_id;
  logic [4:0] piece_col;
  logic [4:0] piece_row;
  logic       spawn;

  modport master (
    output key_valid, key_code, pix_x, pix_y,
    input  pix_hit, piece_id, piece_col, piece_row, spawn
  );

  modport slave (
    input  key_valid, key_code, pix_x, pix_y,
    output pix_hit, piece_id, piece_col, piece_row, spawn
  );
endinterface

// File: rtl/piece_pixel_hit.sv
// Combinational test of whether a pixel falls in an occupied cell of a 4x4 piece mask.
module piece_pixel_hit #(
  parameter int unsigned CELL = 40
) (
  input  logic [4:0]  col_i,
  input  logic [4:0]  row_i,
  input  logic [15:0] mask_i,
  input  logic [9:0]  pix_x_i,
  input  logic [9:0]  pix_y_i,
  output logic        hit_o
);

  logic [15:0] x0, y0, px, py;
  logic [3:0]  in_x, in_y;

  // Half-open cell windows built from constant multiples of CELL, no division.
  always_comb begin
    x0 = 16'(col_i) * 16'(CELL);
    y0 = 16'(row_i) * 16'(CELL);
    px = {6'b0, pix_x_i};
    py = {6'b0, pix_y_i};
    for (int k = 0; k < 4; k++) begin
      in_x[k] = (px >= x0 + 16'(k * CELL)) && (px < x0 + 16'((k + 1) * CELL));
      in_y[k] = (py >= y0 + 16'(k * CELL)) && (py < y0 + 16'((k + 1) * CELL));
    end
    hit_o = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask_i[r*4+c] && in_x[c] && in_y[r]) hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/falling_piece_ctrl.sv
// Falling-piece engine: gravity divider, key moves/rotation with wall checks, spawn and pause,
// plus a registered per-pixel coverage answer for the pixel mux.
module falling_piece_ctrl
  import falling_piece_pkg::*;
#(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned CELL     = 40,
  parameter int unsigned TICK_DIV = 200000,
  parameter int unsigned N_SHAPES = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  falling_piece_if.slave bus
);

  localparam int unsigned DivW      = $clog2(TICK_DIV);
  localparam logic [5:0]  Cols6     = 6'(H_RES / CELL);
  localparam logic [5:0]  Rows6     = 6'(V_RES / CELL);
  localparam logic [2:0]  LastShape = 3'(N_SHAPES - 1);

  state_e          state_q, state_d;
  logic [2:0]      shape_q, shape_d, shape_inc;
  logic [15:0]     mask_q, mask_d, rot_mask, spawn_mask;
  logic [4:0]      col_q, col_d, row_q, row_d;
  logic [DivW-1:0] div_q, div_d;
  logic            tick_pending_q, tick_pending_d;
  logic            pix_hit_q, hit;
  logic            tick, tick_now, step_req, row_fits, rot_fits;
  logic [5:0]      col6, row6, cur_w, cur_h, rot_w, rot_h, spawn_w;
  logic            key_left, key_right, key_drop, key_rot, key_pause, key_any;

  always_comb begin
    key_left  = bus.key_valid && (bus.key_code == KeyLeft);
    key_right = bus.key_valid && (bus.key_code == KeyRight);
    key_drop  = bus.key_valid && (bus.key_code == KeyDrop);
    key_rot   = bus.key_valid && (bus.key_code == KeyRot);
    key_pause = bus.key_valid && (bus.key_code == KeyPause);
    key_any   = key_left | key_right | key_drop | key_rot | key_pause;

    tick     = (div_q == DivW'(TICK_DIV - 1));
    div_d    = tick ? '0 : div_q + DivW'(1);
    tick_now = tick | tick_pending_q;

    col6       = {1'b0, col_q};
    row6       = {1'b0, row_q};
    cur_w      = mask_w(mask_q);
    cur_h      = mask_h(mask_q);
    rot_mask   = rot_cw(mask_q);
    rot_w      = mask_w(rot_mask);
    rot_h      = mask_h(rot_mask);
    rot_fits   = (col6 + rot_w <= Cols6) && (row6 + rot_h <= Rows6);
    row_fits   = (row6 + 6'd1 + cur_h) <= Rows6;
    shape_inc  = (shape_q >= LastShape) ? 3'd0 : shape_q + 3'd1;
    spawn_mask = SHAPE_MASK[shape_inc];
    spawn_w    = mask_w(spawn_mask);
    // A recognised key claims the cycle; a coincident tick waits one cycle.
    step_req   = key_drop || (!key_any && tick_now);
  end

  always_comb begin
    state_d        = state_q;
    shape_d        = shape_q;
    mask_d         = mask_q;
    col_d          = col_q;
    row_d          = row_q;
    tick_pending_d = tick_pending_q;

    case (state_q)
      StFall: begin
        if (key_pause) begin
          state_d        = StPause;
          tick_pending_d = 1'b0;
        end else begin
          tick_pending_d = key_any ? tick_now : 1'b0;
          if (key_left && col_q != 5'd0) col_d = col_q - 5'd1;
          if (key_right && (col6 + 6'd1 + cur_w <= Cols6)) col_d = col_q + 5'd1;
          if (key_rot && rot_fits) mask_d = rot_mask;
          if (step_req) begin
            if (row_fits) row_d = row_q + 5'd1;
            else          state_d = StSpawn;
          end
        end
      end
      StSpawn: begin
        shape_d        = shape_inc;
        mask_d         = spawn_mask;
        row_d          = 5'd0;
        col_d          = (col6 + spawn_w > Cols6) ? 5'(Cols6 - spawn_w) : col_q;
        tick_pending_d = tick_now;
        state_d        = StFall;
      end
      StPause: begin
        tick_pending_d = 1'b0;
        if (key_pause) state_d = StFall;
      end
      default: state_d = StFall;
    endcase
  end

  piece_pixel_hit #(
    .CELL(CELL)
  ) u_pixel_hit (
    .col_i  (col_q),
    .row_i  (row_q),
    .mask_i (mask_q),
    .pix_x_i(bus.pix_x),
    .pix_y_i(bus.pix_y),
    .hit_o  (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StFall;
      shape_q        <= 3'd0;
      mask_q         <= SHAPE_MASK[0];
      col_q          <= 5'd0;
      row_q          <= 5'd0;
      div_q          <= '0;
      tick_pending_q <= 1'b0;
      pix_hit_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shape_q        <= shape_d;
      mask_q         <= mask_d;
      col_q          <= col_d;
      row_q          <= row_d;
      div_q          <= div_d;
      tick_pending_q <= tick_pending_d;
      pix_hit_q      <= hit;
    end
  end

  assign bus.pix_hit   = pix_hit_q;
  assign bus.piece_id  = shape_q;
  assign bus.piece_col = col_q;
  assign bus.piece_row = row_q;
  assign bus.spawn     = (state_q == StSpawn);

endmodule

// File: tb/tb_falling_piece_ctrl.sv
// Self-checking bench for falling_piece_ctrl with a fast gravity divider (TICK_DIV = 4).
module tb_falling_piece_ctrl;
  import falling_piece_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  falling_piece_if bus ();

  falling_piece_ctrl #(
    .H_RES   (640),
    .V_RES   (480),
    .CELL    (40),
    .TICK_DIV(4),
    .N_SHAPES(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
  } pix_vec_t;

  typedef struct {
    logic [7:0] code;
    int         col;
  } key_vec_t;

  int       n_checks = 0;
  int       n_pass = 0;
  logic     exp_q[$];
  pix_vec_t pix_tab[8];
  key_vec_t key_tab[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Expected hit is queued when the query is driven and retired when pix_hit updates.
  task automatic pix_query(input string name, input logic [9:0] x, input logic [9:0] y,
                           input logic exp_hit);
    logic exp;
    bus.pix_x = x;
    bus.pix_y = y;
    exp_q.push_back(exp_hit);
    step();
    exp = exp_q.pop_front();
    check(name, int'(bus.pix_hit), int'(exp));
  endtask

  task automatic wait_spawn(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bus.spawn) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_col;
    int found;
    logic toggle;

    pix_tab[0] = '{10'd80,  10'd120, 1'b1};
    pix_tab[1] = '{10'd159, 10'd199, 1'b1};
    pix_tab[2] = '{10'd160, 10'd120, 1'b0};
    pix_tab[3] = '{10'd79,  10'd120, 1'b0};
    pix_tab[4] = '{10'd120, 10'd160, 1'b1};
    pix_tab[5] = '{10'd100, 10'd200, 1'b0};
    pix_tab[6] = '{10'd239, 10'd130, 1'b0};
    pix_tab[7] = '{10'd0,   10'd0,   1'b0};

    key_tab[0] = '{KeyRot,   12};
    key_tab[1] = '{KeyRight, 13};
    key_tab[2] = '{KeyRight, 14};
    key_tab[3] = '{KeyRight, 15};
    key_tab[4] = '{KeyRight, 15};
    key_tab[5] = '{KeyRot,   15};
    key_tab[6] = '{KeyPause, 15};

    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.pix_x     = 10'd0;
    bus.pix_y     = 10'd0;

    // Reset values, then free fall of shape 0 to the floor.
    do_reset();
    check("rst_id", int'(bus.piece_id), 0);
    check("rst_col", int'(bus.piece_col), 0);
    check("rst_row", int'(bus.piece_row), 0);
    check("rst_spawn", int'(bus.spawn), 0);
    check("rst_pix_hit", int'(bus.pix_hit), 0);

    wait_spawn(n);
    check("drop_spawn_cycle", n, 44);
    check("drop_row_at_spawn", int'(bus.piece_row), 10);
    check("drop_id_at_spawn", int'(bus.piece_id), 0);
    step();
    check("drop_id_after", int'(bus.piece_id), 1);
    check("drop_row_after", int'(bus.piece_row), 0);
    check("drop_spawn_low", int'(bus.spawn), 0);

    // Right wall with the 4-wide shape 1.
    exp_col = 0;
    for (int i = 0; i < 20; i++) begin
      press(KeyRight);
      exp_col = (exp_col < 12) ? exp_col + 1 : 12;
      check("right_wall_col", int'(bus.piece_col), exp_col);
    end

    // Rotation of shape 2 and rejection at the right wall.
    wait_spawn(n);
    check("shape2_spawn_seen", int'(n != 0), 1);
    step();
    check("shape2_id", int'(bus.piece_id), 2);
    check("shape2_col", int'(bus.piece_col), 12);
    check("shape2_row", int'(bus.piece_row), 0);
    for (int i = 0; i < 7; i++) begin
      press(key_tab[i].code);
      check("rot_seq_col", int'(bus.piece_col), key_tab[i].col);
    end
    check("rot_seq_row", int'(bus.piece_row), 0);
    pix_query("bar_bottom_cell", 10'd620, 10'd150, 1'b1);
    pix_query("bar_below", 10'd620, 10'd170, 1'b0);
    pix_query("bar_left_of", 10'd590, 10'd10, 1'b0);
    pix_query("bar_corner", 10'd639, 10'd0, 1'b1);

    // Shape 0 parked at col 2, row 3 under pause, then the pixel table.
    do_reset();
    press(KeyRight);
    press(KeyRight);
    check("park_col", int'(bus.piece_col), 2);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.piece_row == 5'd3) begin
        found = 1;
        break;
      end
      step();
    end
    check("park_row3_reached", found, 1);
    press(KeyPause);
    check("pause_row", int'(bus.piece_row), 3);
    repeat (50) step();
    check("pause_row_held", int'(bus.piece_row), 3);
    press(KeyLeft);
    check("pause_ignores_left", int'(bus.piece_col), 2);
    for (int i = 0; i < 8; i++) begin
      pix_query($sformatf("pix_tab[%0d]", i), pix_tab[i].x, pix_tab[i].y, pix_tab[i].hit);
    end
    press(KeyPause);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.piece_row == 5'd4) begin
        found = 1;
        break;
      end
    end
    check("resume_falls", found, 1);

    // A key in every tick cycle: each row step lands one cycle late, none is lost.
    do_reset();
    exp_col = 0;
    toggle  = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i % 4 == 3) begin
        press(toggle ? KeyLeft : KeyRight);
        exp_col = toggle ? exp_col - 1 : exp_col + 1;
        toggle  = ~toggle;
      end else begin
        step();
      end
      check("collide_row", int'(bus.piece_row), i / 4);
      check("collide_col", int'(bus.piece_col), exp_col);
    end
    step();
    check("collide_spawn", int'(bus.spawn), 1);

    // Reset while in SPAWN.
    bus.pix_x = 10'd0;
    bus.pix_y = 10'd0;
    rst_n = 1'b0;
    step();
    check("spawn_rst_id", int'(bus.piece_id), 0);
    check("spawn_rst_col", int'(bus.piece_col), 0);
    check("spawn_rst_row", int'(bus.piece_row), 0);
    check("spawn_rst_spawn", int'(bus.spawn), 0);
    check("spawn_rst_pix_hit", int'(bus.pix_hit), 0);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
